// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / NIB_W);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit borrow-lookahead slice: d = a - b - bin, computed as a + ~b + ~bin.
module sub4_slice
    import serial_sub_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);

    logic [NIB_W-1:0] nb;
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign nb = ~b;
    assign g  = a & nb;
    assign p  = a ^ nb;

    // Carries expanded in parallel from g/p so no carry ripples through the slice.
    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign d    = p ^ c[NIB_W-1:0];
    assign bout = ~c[4];

endmodule

// File: rtl/serial_sub16.sv
// Nibble-serial subtractor: one 4-bit slice iterated WIDTH/4 times, valid/ready on both sides.
module serial_sub16
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int N  = WIDTH / NIB_W;
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_next;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [NIB_W-1:0] slice_d;
    logic             slice_bout;
    logic             last_step;

    sub4_slice u_slice (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .bin  (brw),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // New nibble enters at the top; after N steps the first nibble sits at bit 0.
    generate
        if (N > 1) begin : g_wide
            assign diff_next = {slice_d, diff_sh[WIDTH-1:NIB_W]};
        end else begin : g_narrow
            assign diff_next = slice_d;
        end
    endgenerate

    assign last_step = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        brw     <= bin;
                        cnt     <= '0;
                        diff_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> NIB_W;
                    b_sh    <= b_sh >> NIB_W;
                    diff_sh <= diff_next;
                    brw     <= slice_bout;
                    cnt     <= cnt + 1'b1;
                    if (last_step) begin
                        diff <= diff_next;
                        bout <= slice_bout;
                        zero <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_sub16.md
# serial_sub16

Nibble-serial multi-cycle subtractor computing A − B − bin on WIDTH-bit unsigned operands, four bits per clock, through a single 4-bit borrow-lookahead slice. It is the subtract-side companion to the team's 4-bit carry-lookahead adder and trades latency for area in datapaths that already sequence nibble-wide arithmetic. Operands enter and results leave over valid/ready handshakes.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operands a, b, bin are valid
- in_ready  out  1  block accepts operands; high only in IDLE
- a  in  WIDTH  minuend, unsigned
- b  in  WIDTH  subtrahend, unsigned
- bin  in  1  borrow-in, subtracted at bit 0
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts the result
- diff  out  WIDTH  (a − b − bin) mod 2^WIDTH
- bout  out  1  borrow-out; 1 iff a < b + bin (unsigned)
- zero  out  1  1 iff diff == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, register a, b, bin into operand shift registers, set the borrow register to bin, clear the nibble counter, go to RUN.
- RUN: each cycle the slice takes a[3:0], b[3:0] of the shifted operands plus the borrow register. It writes the 4-bit difference into the top nibble of the diff shift register, shifting diff right by 4. The slice borrow-out goes to the borrow register and the counter increments. After step N−1, latch the final borrow into bout, compute zero from the completed diff, and go to DONE.
- Slice arithmetic: D = a + ~b + ~borrow_in, 4 bits. Borrow_out = NOT carry_out. Internal generate/propagate terms are computed lookahead-style, not rippled.
- DONE: out_valid = 1. diff, bout and zero are held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. Operands are never accepted in the same cycle a result is retired, so there is no overlap.
- Reset at any time, including mid-RUN or in DONE with out_ready low: return to IDLE immediately and abandon the operation. No partial result is emitted.

## Timing
- Reset values: in_ready = 1, out_valid = 0, diff = 0, bout = 0, zero = 0. All internal registers are cleared.
- Accept at edge T. RUN covers edges T+1 through T+N. out_valid is high from edge T+N. Latency is N cycles (4 for WIDTH = 16).
- out_valid stays high until the edge where out_ready = 1. in_ready rises at that same edge, so the next accept can occur one cycle later. Throughput is at most one result per N+2 cycles.
- out_ready asserted before out_valid has no effect.
- diff, bout and zero change only at the entry to DONE or on reset.

## Structure
- Package serial_sub_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - NIB_W = 4
  - a function returning the counter width, clog2(WIDTH/4) with a minimum of 1
- Sub-module sub4_slice is combinational: inputs a[3:0], b[3:0], bin; outputs d[3:0], bout. It uses the same generate/propagate lookahead structure as the team adder with B inverted. Exactly one instance.
- The top level contains the FSM, counter, operand and diff shift registers, borrow register and zero detect.

## Test plan
- a = 0x1234, b = 0x0234, bin = 0: after 4 cycles, diff = 0x1000, bout = 0, zero = 0.
- a = 0x1000, b = 0x0001, bin = 0 (borrow ripples across three nibbles): diff = 0x0FFF, bout = 0.
- a = 0x0000, b = 0x0001, bin = 0: diff = 0xFFFF, bout = 1. Also a = 0x0000, b = 0x0000, bin = 1: diff = 0xFFFF, bout = 1.
- a = 0x8000, b = 0x8000, bin = 0: diff = 0x0000, zero = 1, bout = 0.
- Backpressure: hold out_ready low for 3 cycles after out_valid while driving in_valid with new operands. Required: outputs stable, in_ready = 0, no new operands accepted. Then pulse out_ready: in_ready rises the next cycle and the second operation completes correctly.
- Reset: assert rst_n = 0 during the 2nd RUN cycle. Required: all outputs return to reset values asynchronously. After release, a fresh 0x0005 − 0x0003 yields diff = 0x0002, with no residue from the aborted operation.
